// File: rtl/input_current_scheduler.sv
// Shares one 8-input synaptic current calculator across N neurons: snapshots the
// layer spikes on start, issues each neuron's weight slice in turn, and stores the results.
module input_current_scheduler #(
    parameter int M = 8,
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [M-1:0]      input_spikes,
    input  logic [N*M*8-1:0]  weights_all,
    input  logic [7:0]        calc_current,
    output logic              calc_enable,
    output logic [M-1:0]      calc_spikes,
    output logic [M*8-1:0]    calc_weights,
    output logic [N*8-1:0]    currents_out,
    output logic [IW-1:0]     neuron_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t             r_state;
    state_t             w_next;
    logic [IW-1:0]      r_idx;
    logic [M-1:0]       r_spikes;
    logic [N*8-1:0]     r_currents;

    // State register; reset abandons any evaluation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: one ISSUE/CAPTURE pair per neuron, then a single DONE cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_ISSUE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: begin
                if (r_idx == LAST_IDX) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_ISSUE;
                end
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath: spike snapshot, neuron index and per-neuron result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx      <= '0;
            r_spikes   <= '0;
            r_currents <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_spikes <= input_spikes;
                        r_idx    <= '0;
                    end
                end
                S_CAPTURE: begin
                    r_currents[r_idx*8 +: 8] <= calc_current;
                    // Index stays at the last neuron after the sweep until the next start.
                    if (r_idx != LAST_IDX) begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign calc_enable  = (r_state == S_ISSUE);
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign calc_spikes  = r_spikes;
    assign calc_weights = weights_all[r_idx*M*8 +: M*8];
    assign currents_out = r_currents;
    assign neuron_idx   = r_idx;

endmodule

// File: tb/tb_input_current_scheduler.sv
// Directed bench for input_current_scheduler with a behavioural clamped-sum calculator.
module tb_input_current_scheduler;

    localparam int M = 8;
    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [M-1:0]      input_spikes;
    logic [N*M*8-1:0]  weights_all;
    logic [7:0]        calc_current = 8'h00;
    logic              calc_enable;
    logic [M-1:0]      calc_spikes;
    logic [M*8-1:0]    calc_weights;
    logic [N*8-1:0]    currents_out;
    logic [1:0]        neuron_idx;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;

    input_current_scheduler #(.M(M), .N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .input_spikes(input_spikes),
        .weights_all(weights_all), .calc_current(calc_current), .calc_enable(calc_enable),
        .calc_spikes(calc_spikes), .calc_weights(calc_weights), .currents_out(currents_out),
        .neuron_idx(neuron_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] calc_model(input logic [7:0] sp, input logic [63:0] w);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            if (sp[i]) s += int'($signed(w[i*8 +: 8]));
        end
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s[7:0];
    endfunction

    // Calculator stand-in: registers the clamped sum on enable, holds otherwise.
    always @(posedge clk) begin
        if (calc_enable) calc_current <= calc_model(calc_spikes, calc_weights);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string        name;
        logic [7:0]   spikes;
        logic [255:0] weights;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs[3];

    // Starts an evaluation (the edge after this call is E0) and returns with start low.
    task automatic kick(input logic [7:0] sp, input logic [255:0] w);
        @(posedge clk); #1;
        input_spikes = sp;
        weights_all  = w;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_eval(input string name, input logic [7:0] sp, input logic [255:0] w,
                            input logic [31:0] ex);
        int busy_n, en_n, done_n, done_c, b2b, idx_bad;
        logic prev_en;
        busy_n = 0; en_n = 0; done_n = 0; done_c = -1; b2b = 0; idx_bad = 0; prev_en = 1'b0;
        kick(sp, w);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (calc_enable) begin
                if (prev_en) b2b++;
                if (int'(neuron_idx) != en_n) idx_bad++;
                en_n++;
            end
            prev_en = calc_enable;
            if (done) begin
                done_n++;
                done_c = c;
            end
        end
        chk({name, " busy_cycles"}, 64'(busy_n), 64'd9);
        chk({name, " enable_pulses"}, 64'(en_n), 64'd4);
        chk({name, " enable_back_to_back"}, 64'(b2b), 64'd0);
        chk({name, " idx_on_issue"}, 64'(idx_bad), 64'd0);
        chk({name, " done_pulses"}, 64'(done_n), 64'd1);
        chk({name, " done_cycle"}, 64'(done_c), 64'd8);
        chk({name, " currents_out"}, 64'(currents_out), 64'(ex));
    endtask

    initial begin
        int done_n, busy_n, spk_bad, d0, d1, d2;

        // Unspiked input 7 carries weight 50 to confirm masking.
        vecs[0].name    = "basic";
        vecs[0].spikes  = 8'b0000_0011;
        vecs[0].weights = {64'h0000_0000_0000_0000, 64'h3200_0000_0000_9C9C,
                           64'h3200_0000_0000_6464, 64'h3200_0000_0000_140A};
        vecs[0].exp     = {8'h00, 8'h80, 8'h7F, 8'h1E};
        vecs[1].name    = "mixed";
        vecs[1].spikes  = 8'hA5;
        vecs[1].weights = {64'h0706_0504_0302_0100, {8{8'h7F}}, {8{8'hFF}}, {8{8'h01}}};
        vecs[1].exp     = {8'h0E, 8'h7F, 8'hFC, 8'h04};
        vecs[2].name    = "all7";
        vecs[2].spikes  = 8'hFF;
        vecs[2].weights = {32{8'h07}};
        vecs[2].exp     = {4{8'h38}};

        reset = 1'b1; start = 1'b0; input_spikes = 8'h00; weights_all = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset enable", 64'(calc_enable), 64'd0);
        chk("reset idx", 64'(neuron_idx), 64'd0);
        chk("reset spikes", 64'(calc_spikes), 64'd0);
        chk("reset currents", 64'(currents_out), 64'd0);
        #1 reset = 1'b0;

        for (int v = 0; v < 3; v++) begin
            run_eval(vecs[v].name, vecs[v].spikes, vecs[v].weights, vecs[v].exp);
        end

        // Retention: previous run left 56 everywhere; rerun with no spikes.
        kick(8'h00, {32{8'h07}});
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c == 2) begin
                chk("retain cur3 midrun", 64'(currents_out[31:24]), 64'd56);
                chk("retain cur0 rewritten", 64'(currents_out[7:0]), 64'd0);
            end
            if (c == 8) begin
                chk("retain done", 64'(done), 64'd1);
                chk("retain all zero", 64'(currents_out), 64'd0);
            end
        end

        // Snapshot: spikes change at E0+1 and a stray start at E0+3 must not matter.
        done_n = 0; busy_n = 0; spk_bad = 0;
        kick(8'h01, {192'd0, 64'h0000_0000_0000_0005});
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (busy) begin
                busy_n++;
                if (calc_spikes !== 8'h01) spk_bad++;
            end
            if (done) done_n++;
            @(posedge clk); #1;
            if (c + 1 == 1) input_spikes = 8'hFF;
            if (c + 1 == 2) start = 1'b1;
            if (c + 1 == 3) start = 1'b0;
        end
        chk("snap spikes held", 64'(spk_bad), 64'd0);
        chk("snap done_pulses", 64'(done_n), 64'd1);
        chk("snap busy_cycles", 64'(busy_n), 64'd9);
        chk("snap cur0", 64'(currents_out[7:0]), 64'd5);

        // Reset during CAPTURE of neuron 2.
        kick(vecs[0].spikes, vecs[0].weights);
        repeat (6) @(negedge clk);
        chk("midreset pre idx", 64'(neuron_idx), 64'd2);
        chk("midreset pre enable", 64'(calc_enable), 64'd0);
        #1 reset = 1'b1;
        #1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        chk("midreset currents", 64'(currents_out), 64'd0);
        @(negedge clk); #1 reset = 1'b0;
        done_n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) done_n++;
        end
        chk("midreset no activity", 64'(done_n), 64'd0);
        run_eval("after_reset", vecs[0].spikes, vecs[0].weights, vecs[0].exp);

        // Back-to-back: start held high.
        d0 = -1; d1 = -1; d2 = -1; done_n = 0;
        @(posedge clk); #1;
        input_spikes = vecs[1].spikes; weights_all = vecs[1].weights; start = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) begin
                if (done_n == 0) d0 = c;
                if (done_n == 1) d1 = c;
                if (done_n == 2) d2 = c;
                done_n++;
            end
            if (c == 9) chk("b2b idle gap", 64'(busy), 64'd0);
        end
        start = 1'b0;
        chk("b2b done_pulses", 64'(done_n), 64'd3);
        chk("b2b first_done", 64'(d0), 64'd8);
        chk("b2b spacing1", 64'(d1 - d0), 64'd10);
        chk("b2b spacing2", 64'(d2 - d1), 64'd10);
        chk("b2b currents", 64'(currents_out), 64'(vecs[1].exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
